// File: rtl/rr_mask_arbiter.sv
// rr_mask_arbiter: N-way round-robin arbiter with a registered grant that is
// held until the served requester acks it or drops its request.
// The rotation pointer advances past the served index on every ack.
// Optional macro RR_ARB_TIMEOUT_EN adds a hold counter that revokes a grant
// held TIMEOUT cycles without ack and pulses the timeout output.
module rr_mask_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N-1:0]                        req,
    input  logic                                ack,
    output logic [N-1:0]                        grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
    output logic                                grant_valid
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic                                timeout
`endif
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    if (N < 1 || N > 32) begin : g_bad_n
        $error("rr_mask_arbiter: N must be in 1..32");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("rr_mask_arbiter: TIMEOUT must be in 2..65535");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx;
    logic [PTR_W-1:0]   id_inc;
    logic [N-1:0]       grant_nx;
    logic [PTR_W-1:0]   id_nx;
    logic               valid_nx;
    logic               arb_go;
    logic [N-1:0]       arb_r;
    logic [PTR_W-1:0]   arb_p;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               load;
`ifdef RR_ARB_TIMEOUT_EN
    logic [15:0]        hold_cnt;
    logic               pulse_nx;
`endif

    // Lowest requester at or above p; otherwise lowest requester overall.
    // Returns {found, index}.
    function automatic logic [PTR_W:0] arb(input logic [N-1:0] r,
                                           input logic [PTR_W-1:0] p);
        logic             hi_found;
        logic             lo_found;
        logic [PTR_W-1:0] hi_idx;
        logic [PTR_W-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(i);
            end
            if (r[i] && !hi_found && (i >= 32'(p))) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(i);
            end
        end
        if (hi_found)      return {1'b1, hi_idx};
        else if (lo_found) return {1'b1, lo_idx};
        else               return '0;
    endfunction

    // Next-state decision: pick the arbitration inputs for this edge, then
    // either load the winner or fall back to IDLE.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        grant_nx = grant;
        id_nx    = grant_id;
        valid_nx = grant_valid;
        arb_go   = 1'b0;
        arb_r    = '0;
        arb_p    = '0;
        load     = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        pulse_nx = 1'b0;
`endif
        id_inc = (grant_id == PTR_W'(N - 1)) ? '0 : grant_id + PTR_W'(1);

        case (state)
            IDLE: begin
                if (|req) begin
                    arb_go = 1'b1;
                    arb_r  = req;
                    arb_p  = ptr;
                end
            end
            BUSY: begin
                if (ack) begin
                    ptr_nx = id_inc;
                    arb_go = 1'b1;
                    arb_r  = req & ~grant;
                    arb_p  = id_inc;
                end else if (!req[grant_id]) begin
                    arb_go = 1'b1;
                    arb_r  = req;
                    arb_p  = ptr;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_cnt == 16'(TIMEOUT - 1)) begin
                    ptr_nx   = id_inc;
                    arb_go   = 1'b1;
                    arb_r    = req & ~grant;
                    arb_p    = id_inc;
                    pulse_nx = 1'b1;
                end
`endif
            end
            default: ;
        endcase

        {win_found, win_idx} = arb(arb_r, arb_p);

        if (arb_go) begin
            if (win_found) begin
                load     = 1'b1;
                state_nx = BUSY;
                id_nx    = win_idx;
                valid_nx = 1'b1;
                for (int unsigned i = 0; i < N; i++) begin
                    grant_nx[i] = (PTR_W'(i) == win_idx);
                end
            end else begin
                state_nx = IDLE;
                id_nx    = '0;
                valid_nx = 1'b0;
                grant_nx = '0;
            end
        end
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            grant       <= grant_nx;
            grant_id    <= id_nx;
            grant_valid <= valid_nx;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter restarts on every grant load and counts un-acked BUSY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= pulse_nx;
            if (load || state == IDLE) begin
                hold_cnt <= '0;
            end else if (!ack) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_mask_arbiter.sv
// Testbench for rr_mask_arbiter (N=4, TIMEOUT=4): directed vectors, a rotating
// scan model checked every cycle, and literal expectations from hand traces.
// Define RR_ARB_TIMEOUT_EN for both files to exercise the timeout scenarios.
module tb_rr_mask_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         grant_valid;
`ifdef RR_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rr_mask_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
`ifdef RR_ARB_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 idle), pointer, hold count, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    // Scan p, p+1, ... wrapping; first requester found wins.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] rr;
        int nx;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (req != '0) begin
                m_owner = pick(req, m_ptr);
                m_hold  = 0;
            end
        end else if (ack) begin
            nx = (m_owner + 1) % N;
            m_ptr = nx;
            rr = req;
            rr[m_owner] = 1'b0;
            m_owner = pick(rr, nx);
            m_hold  = 0;
        end else if (!req[m_owner]) begin
            m_owner = pick(req, m_ptr);
            m_hold  = 0;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (m_hold == TMO - 1) begin
            nx = (m_owner + 1) % N;
            m_ptr = nx;
            rr = req;
            rr[m_owner] = 1'b0;
            m_owner = pick(rr, nx);
            m_hold  = 0;
            m_to    = 1'b1;
        end
`endif
        else begin
            m_hold++;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        if (!rst) begin
            logic [N-1:0] eg;
            model_step();
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            #1;
            check("model_grant", 32'(grant), 32'(eg));
            check("model_grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("model_grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
            check("valid_eq_or_grant", 32'(grant_valid), 32'(|grant));
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
`ifdef RR_ARB_TIMEOUT_EN
            check("model_timeout", 32'(timeout), 32'(m_to));
`endif
        end
    end

    // Called at a negedge: apply inputs, return at the next negedge.
    task automatic tick(input logic [N-1:0] r, input logic a);
        req = r;
        ack = a;
        @(negedge clk);
    endtask

    task automatic expect_g(input string name, input logic [N-1:0] g, input int id);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_id"}, 32'(grant_id), 32'(id));
        check({name, "_valid"}, 32'(grant_valid), 32'(g != '0));
    endtask

    logic [N-1:0] seq [5];

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;

        repeat (2) @(negedge clk);
        expect_g("reset", 4'b0000, 0);
        rst = 1'b0;

        // Full request, ack every third cycle: rotating grants, no bubbles.
        for (int g = 0; g < 5; g++) begin
            tick(4'b1111, 1'b0);
            tick(4'b1111, 1'b0);
            expect_g("rotate", seq[g], g % N);
            tick(4'b1111, 1'b1);
            check("rotate_no_bubble", 32'(grant_valid), 32'd1);
        end
        // Holder 1 now, ack with no requests -> idle, ptr=2.
        tick(4'b0000, 1'b1);
        expect_g("drain", 4'b0000, 0);

        // Single requester 2, acked each time.
        for (int k = 0; k < 3; k++) begin
            tick(4'b0100, 1'b0);
            expect_g("single", 4'b0100, 2);
            tick(4'b0100, 1'b1);
            expect_g("single_idle", 4'b0000, 0);
        end

        // ptr=3, req 0011 wraps to requester 0; ack hands straight to 1.
        tick(4'b0011, 1'b0);
        expect_g("wrap", 4'b0001, 0);
        tick(4'b0011, 1'b1);
        expect_g("b2b", 4'b0010, 1);
        tick(4'b0011, 1'b0);
        expect_g("hold", 4'b0010, 1);
        // Cancel of requester 1 with 1001 pending -> 3, ptr stays 1.
        tick(4'b1001, 1'b0);
        expect_g("cancel", 4'b1000, 3);

        // Async reset mid-grant.
        rst = 1'b1;
        #1;
        expect_g("async_rst", 4'b0000, 0);
        m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        req = '0; ack = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        tick(4'b0010, 1'b0);
        expect_g("post_rst", 4'b0010, 1);

        // Ack -> ptr=2; then cancel must not move the pointer.
        tick(4'b0010, 1'b1);
        tick(4'b1010, 1'b0);
        expect_g("ptr2", 4'b1000, 3);
        tick(4'b0011, 1'b0);
        expect_g("cancel_wrap", 4'b0001, 0);
        tick(4'b0111, 1'b0);
        tick(4'b0110, 1'b0);
        expect_g("cancel_ptr_kept", 4'b0100, 2);

        // Ack and cancel together count as ack: ptr -> 3.
        tick(4'b0011, 1'b1);
        expect_g("ack_cancel", 4'b0001, 0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        expect_g("idle_ack", 4'b0000, 0);
        tick(4'b0110, 1'b0);
        expect_g("ack_won", 4'b0010, 1);

`ifdef RR_ARB_TIMEOUT_EN
        // Revocation after TMO cycles without ack.
        tick(4'b0000, 1'b1);
        tick(4'b0011, 1'b0);
        expect_g("to_load", 4'b0001, 0);
        for (int k = 0; k < TMO - 1; k++) begin
            tick(4'b0011, 1'b0);
            expect_g("to_hold", 4'b0001, 0);
            check("to_quiet", 32'(timeout), 32'd0);
        end
        tick(4'b0011, 1'b0);
        expect_g("to_revoke", 4'b0010, 1);
        check("to_pulse", 32'(timeout), 32'd1);
        tick(4'b0011, 1'b1);
        check("to_pulse_end", 32'(timeout), 32'd0);
        // Ack on the timeout edge wins: no pulse.
        tick(4'b0000, 1'b1);
        tick(4'b0011, 1'b0);
        for (int k = 0; k < TMO - 1; k++) tick(4'b0011, 1'b0);
        tick(4'b0011, 1'b1);
        expect_g("to_ack", 4'b0010, 1);
        check("to_ack_nopulse", 32'(timeout), 32'd0);
`endif

        tick(4'b0000, 1'b1);
        expect_g("final_idle", 4'b0000, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mask_arbiter.md
Name: rr_mask_arbiter

Overview:
- Parametrised round-robin arbiter for N requesters, successor to the fixed 4-way masked priority arbiter.
- The rotation pointer is internal and self-advancing; the pointer input is removed.
- The grant is registered and held until the served requester acknowledges it.
- Sits between N request sources and one shared resource, e.g. a bus master port or a FIFO write port.

Parameters:
- N, 4, number of requesters; legal range 1..32.
- PTR_W, derived localparam, (N>1) ? $clog2(N) : 1; width of pointer and grant_id.
- TIMEOUT, 16, maximum grant hold in cycles without ack; legal range 2..65535; used only with RR_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- ack  input  1  resource finished with the current grant; sampled only while grant_valid=1.
- grant  output  N  one-hot registered grant; all zero when idle.
- grant_id  output  PTR_W  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high while grant is non-zero.
- timeout  output  1  one-cycle pulse on grant revocation; present only with RR_ARB_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1): grant=0, grant_id=0, grant_valid=0, timeout=0, ptr=0, state IDLE. Asserting rst mid-grant clears all outputs immediately and discards the pending grant.
- State register: IDLE, BUSY.
- Arbitration function ARB(r, p):
  - mask = bits index>=p set.
  - If (r & mask) != 0, pick the lowest set index of r & mask.
  - Otherwise pick the lowest set index of r.
  - r == 0 gives no winner.
- IDLE: if req != 0 at an edge, winner = ARB(req, ptr). At that edge: grant = onehot(winner), grant_id = winner, grant_valid=1, go BUSY. Latency is 1 cycle from req sampled to grant visible.
- BUSY with ack=1 at an edge:
  - ptr <= (grant_id+1) mod N.
  - Re-arbitrate with ARB(req & ~grant, (grant_id+1) mod N).
  - Winner found: load the new grant at the same edge, stay BUSY. This is zero-bubble back-to-back.
  - No winner: clear outputs, go IDLE.
- BUSY, ack=0, req[grant_id]=0 (cancel): ptr unchanged. Re-arbitrate with ARB(req, ptr) at the same edge; same load or IDLE rule as above.
- BUSY, ack=0, req[grant_id]=1: hold all outputs unchanged.
- ack=1 in IDLE: ignored.
- Ack and cancel in the same cycle: treated as ack, so the pointer advances.
- Fairness: a continuously asserted request is granted within N grants.
- Pointer wrap: grant_id=N-1 with ack gives ptr=0.
- N=1: ptr is constant 0; grant is req[0] gated by the FSM.
- Grant is never multi-hot; grant_valid == |grant at all times.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- With macro defined:
  - A 16-bit hold counter clears on every new grant load and increments each BUSY cycle with ack=0.
  - When the counter reaches TIMEOUT-1 with ack still 0, the next edge revokes the grant and sets ptr <= (grant_id+1) mod N.
  - It then re-arbitrates excluding the revoked index for that one decision, and pulses timeout=1 for one cycle.
  - ack at the timeout edge wins: normal ack path, no pulse.
  - Reset clears the counter.
- Without macro: no counter, no timeout port; a grant is held indefinitely until ack or cancel.

Test Plan:
- N=4, reset then req=4'b1111 held, ack pulsed every 3rd cycle -> grant sequence 0001, 0010, 0100, 1000, 0001; grant_valid never drops between grants.
- N=4, req=4'b0100 only, ack every cycle after grant -> grant=0100 each arbitration, ptr cycles 3, then 3, then 3; no spurious grants; grant_id=2.
- N=4, ptr=3 after serving 0100, then req=4'b0011 -> wrap to grant=0001 next edge.
- N=4, grant=0010 held, then req[1] drops with ack=0 while req=4'b1001 -> next edge grant=1000, ptr still 1.
- Assert rst while grant=1000 -> grant, grant_id, grant_valid go 0 without a clock edge; after release, req=4'b0010 -> grant=0010 (ptr reset to 0).
- RR_ARB_TIMEOUT_EN, TIMEOUT=4, req=4'b0011, no ack -> grant=0001 for 4 cycles, then timeout pulse, grant=0010; with ack in 4th cycle, no pulse.
